// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, alignment rule.
package mem_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   // Reserved size 2'b11 falls into the word rule.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_HALF: return addr_lo[0];
         SIZE_BYTE: return 1'b0;
         default:   return addr_lo != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_formatter.sv
// Combinational lane steering: store byte enables/data and load extraction
// with sign or zero extension, little-endian.
module mem_lane_formatter
   import mem_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   input  logic        signed_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      byte_en_o = 4'b1111;
      wdata_o   = wdata_i;
      rdata_o   = rword_i;
      rhalf     = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
      case (addr_lo_i)
         2'd0:    rbyte = rword_i[7:0];
         2'd1:    rbyte = rword_i[15:8];
         2'd2:    rbyte = rword_i[23:16];
         default: rbyte = rword_i[31:24];
      endcase

      // Store data is replicated across lanes; the enables pick the live copy.
      case (size_i)
         SIZE_HALF: begin
            byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o   = {2{wdata_i[15:0]}};
            rdata_o   = {{16{signed_i & rhalf[15]}}, rhalf};
         end
         SIZE_BYTE: begin
            byte_en_o = 4'b0001 << addr_lo_i;
            wdata_o   = {4{wdata_i[7:0]}};
            rdata_o   = {{24{signed_i & rbyte[7]}}, rbyte};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data memory with configurable wait states and stall request.
// Optional performance counters are enabled by defining MEM_PERF_CNT_EN.
module memory_stage
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   output logic [31:0] ReadData,
   output logic        MemStall,
   output logic        AddrError
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0] LoadCount,
   output logic [31:0] StoreCount,
   output logic [31:0] StallCount
`endif
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      mem_q [DEPTH_WORDS];

   logic             req, is_load, is_store, aligned, access;
   logic             stall, complete;
   logic [IDX_W-1:0] word_idx;
   logic [31:0]      raw_word, st_data, ld_data;
   logic [3:0]       byte_en;
   logic             unused_addr_hi;

   assign req      = MemRead | MemWrite;
   assign is_store = MemWrite;
   assign is_load  = MemRead & ~MemWrite;
   assign aligned  = ~is_misaligned(MemSize, Address[1:0]);
   assign access   = req & aligned & ~Rst;
   assign word_idx = Address[IDX_W+1:2];
   assign raw_word = mem_q[word_idx];
   assign unused_addr_hi = ^Address[31:IDX_W+2];

   mem_lane_formatter u_fmt (
      .addr_lo_i (Address[1:0]),
      .size_i    (MemSize),
      .wdata_i   (WriteData),
      .rword_i   (raw_word),
      .signed_i  (MemSigned),
      .byte_en_o (byte_en),
      .wdata_o   (st_data),
      .rdata_o   (ld_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (WAIT_STATES == 0) begin
                  complete = 1'b1;
               end else begin
                  stall   = 1'b1;
                  cnt_d   = CNT_ONE;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // A request that vanishes mid-wait is an abort: no write, back to IDLE.
            if (!access) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q < CNT_LAST) begin
               stall = 1'b1;
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               complete = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end
         end
      endcase
   end

   // NOTE: state registers take non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the data array is deliberately not reset; contents survive Rst and map to plain RAM.
   always_ff @(posedge Clk) begin
      if (complete && is_store) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   assign MemStall  = stall;
   assign AddrError = req & ~aligned & ~Rst;
   assign ReadData  = (complete && is_load) ? ld_data : '0;

`ifdef MEM_PERF_CNT_EN
   logic [31:0] load_cnt_q, store_cnt_q, stall_cnt_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (complete && is_load)  load_cnt_q  <= load_cnt_q + 32'd1;
         if (complete && is_store) store_cnt_q <= store_cnt_q + 32'd1;
         if (stall)                stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign LoadCount  = load_cnt_q;
   assign StoreCount = store_cnt_q;
   assign StallCount = stall_cnt_q;
`endif

endmodule
